// File: rtl/add_sched.sv
`default_nettype none
// ============================================================================
// Module   : add_sched
// Purpose  : Round-robin scheduler sharing one DW-bit adder between NREQ
//            requesters. One operand pair is accepted per grant; the DW+1 bit
//            sum and requester id are registered and held until the consumer
//            accepts them. Completions are counted and a sticky interrupt is
//            raised when the count reaches a programmable threshold.
// Ports    : clk, rst            - clock, async active-high reset
//            req_valid/req_ready - per-requester handshake (ready one-hot/0)
//            req_op1/req_op2     - flattened operands, requester i at [i*DW +: DW]
//            res_valid/res_ready - result handshake
//            res_data/res_id     - registered sum (with carry) and its source
//            cnt_thresh          - completion count raising intr (0 = off)
//            intr_clr/intr       - interrupt clear pulse / sticky interrupt
// Options  : ADD_SCHED_PRIO_EN   - requester 0 gets fixed highest priority
// Revision : 1.0 - initial release
// ============================================================================
module add_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_op1,
  input  logic [NREQ*DW-1:0] req_op2,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW:0]        res_data,
  output logic [IDW-1:0]     res_id,
  input  logic [7:0]         cnt_thresh,
  input  logic               intr_clr,
  output logic               intr
);

  localparam logic [0:0]     C_IDLE    = 1'b0;
  localparam logic [0:0]     C_HOLD    = 1'b1;
  localparam logic [IDW-1:0] C_LAST_ID = IDW'(NREQ - 1);

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW:0]    res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [7:0]     done_cnt_q, done_cnt_d;
  logic           intr_q, intr_d;

  logic [NREQ-1:0] w_rr_vec;
  logic [IDW-1:0]  w_rr_id;
  logic [IDW-1:0]  w_grant_id;
  logic            w_ptr_upd;
  logic            w_accept;
  logic            w_grant_en;
  logic [DW-1:0]   w_op1;
  logic [DW-1:0]   w_op2;
  logic [DW:0]     w_sum;
  logic            w_complete;
  logic [7:0]      w_cnt_inc;
  logic            w_hit;
  int              w_best;
  int              w_dist;

`ifdef ADD_SCHED_PRIO_EN
  // Requester 0 bypasses the rotation; the pointer only tracks the others.
  assign w_rr_vec   = {req_valid[NREQ-1:1], 1'b0};
  assign w_grant_id = req_valid[0] ? '0 : w_rr_id;
  assign w_ptr_upd  = ~req_valid[0];
`else
  assign w_rr_vec   = req_valid;
  assign w_grant_id = w_rr_id;
  assign w_ptr_upd  = 1'b1;
`endif

  // Pick the valid requester at the smallest circular distance from rr_ptr.
  always_comb begin
    w_best  = NREQ;
    w_dist  = 0;
    w_rr_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(rr_ptr_q)) begin
        w_dist = i - int'(rr_ptr_q);
      end else begin
        w_dist = i + NREQ - int'(rr_ptr_q);
      end
      if (w_rr_vec[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_rr_id = IDW'(i);
      end
    end
  end

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_id == IDW'(i)) begin
        w_op1 = req_op1[i*DW +: DW];
        w_op2 = req_op2[i*DW +: DW];
      end
    end
  end

  assign w_sum      = {1'b0, w_op1} + {1'b0, w_op2};
  assign w_accept   = (state_q == C_IDLE) || res_ready;
  // rst gating keeps req_ready low for the whole reset window.
  assign w_grant_en = w_accept && (|req_valid) && !rst;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (w_grant_en) state_d = C_HOLD;
      end
      C_HOLD: begin
        if (res_ready) state_d = w_grant_en ? C_HOLD : C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    res_valid = (state_q == C_HOLD);
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grant_en && (w_grant_id == IDW'(i));
    end
  end

  // Datapath and completion counter
  assign w_complete = (state_q == C_HOLD) && res_ready;
  assign w_cnt_inc  = done_cnt_q + 8'd1;
  assign w_hit      = w_complete && (cnt_thresh != 8'd0) && (w_cnt_inc == cnt_thresh);

  always_comb begin
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (w_grant_en) begin
      res_data_d = w_sum;
      res_id_d   = w_grant_id;
      if (w_ptr_upd) begin
        rr_ptr_d = (w_grant_id == C_LAST_ID) ? '0 : w_grant_id + IDW'(1);
      end
    end
    if (w_hit) begin
      done_cnt_d = 8'd0;
    end else if (w_complete) begin
      done_cnt_d = w_cnt_inc;
    end else begin
      done_cnt_d = done_cnt_q;
    end
    // A threshold hit outranks a simultaneous clear.
    intr_d = w_hit | (intr_q & ~intr_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      done_cnt_q <= '0;
      intr_q     <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      done_cnt_q <= done_cnt_d;
      intr_q     <= intr_d;
    end
  end

  assign res_data = res_data_q;
  assign res_id   = res_id_q;
  assign intr     = intr_q;

endmodule
`default_nettype wire
